// File: rtl/riscv_mem_pkg.sv
// Shared request/response types for the memory channel. Struct fields are sized
// to the widest supported configuration; instances use the low-order bits.
package riscv_mem_pkg;

   localparam int unsigned MEM_DW_MAX = 128;
   localparam int unsigned MEM_BE_MAX = MEM_DW_MAX / 8;
   localparam int unsigned MEM_AW_MAX = 32;

   typedef struct packed {
      logic [MEM_DW_MAX-1:0] rdata;
      logic                  err;
   } mem_rsp_t;

   typedef struct packed {
      logic                  we;
      logic [MEM_AW_MAX-1:0] addr;
      logic [MEM_DW_MAX-1:0] wdata;
      logic [MEM_BE_MAX-1:0] be;
   } mem_req_t;

   function automatic logic [MEM_DW_MAX-1:0] f_be_merge(
      input logic [MEM_DW_MAX-1:0] old_word,
      input logic [MEM_DW_MAX-1:0] new_word,
      input logic [MEM_BE_MAX-1:0] be
   );
      logic [MEM_DW_MAX-1:0] merged;
      merged = old_word;
      for (int unsigned i = 0; i < MEM_BE_MAX; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/riscv_mem_rsp_fifo.sv
// First-word-fall-through response FIFO; pointers wrap modulo P_DEPTH, so any
// depth works, and full/empty come from the occupancy count.
module riscv_mem_rsp_fifo
   import riscv_mem_pkg::*;
#(
   parameter int unsigned P_DEPTH = 4,
   localparam int unsigned P_CW   = $clog2(P_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  mem_rsp_t        push_data,
   input  logic            pop,
   output mem_rsp_t        head,
   output logic            head_valid,
   output logic [P_CW-1:0] count
);

   localparam int unsigned PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

   mem_rsp_t        store [P_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(P_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push    = push && (count != P_CW'(P_DEPTH));
   assign do_pop     = pop && (count != '0);
   assign head_valid = (count != '0);
   assign head       = head_valid ? store[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= f_next(wr_ptr);
         if (do_pop)  rd_ptr <= f_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + P_CW'(1);
            2'b01:   count <= count - P_CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/riscv_mem_channel.sv
// Valid/ready memory channel with byte strobes, pipelined reads and a buffered
// response path. Define RISCV_MEM_WR_ACK_EN to make writes return a response.
module riscv_mem_channel
   import riscv_mem_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = 32,
   parameter int unsigned P_ADDR_WIDTH = 8,
   parameter int unsigned P_DEPTH      = 256,
   parameter int unsigned P_LATENCY    = 1,
   parameter int unsigned P_RSP_DEPTH  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_we,
   input  logic [P_ADDR_WIDTH-1:0]            req_addr,
   input  logic [P_DATA_WIDTH-1:0]            req_wdata,
   input  logic [P_DATA_WIDTH/8-1:0]          req_be,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [P_DATA_WIDTH-1:0]            rsp_rdata,
   output logic                               rsp_err,
   output logic [$clog2(P_RSP_DEPTH+1)-1:0]   outstanding
);

   localparam int unsigned CW = $clog2(P_RSP_DEPTH + 1);
   localparam int unsigned IW = $clog2(P_DEPTH);

   logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
   mem_req_t                req;
   mem_rsp_t                stage_in;
   mem_rsp_t                head;
   logic [MEM_DW_MAX-1:0]   wr_merged;
   logic [IW-1:0]           idx;
   logic                    in_range;
   logic                    accept;
   logic                    rsp_accept;
   logic                    pop;
   logic                    ready_en;
   logic [P_LATENCY-1:0]    pipe_v;
   mem_rsp_t                pipe_d [P_LATENCY];
   logic [CW-1:0]           fifo_count;
   logic                    unused_bits;

   always_comb begin
      req       = '0;
      req.we    = req_we;
      req.addr  = MEM_AW_MAX'(req_addr);
      req.wdata = MEM_DW_MAX'(req_wdata);
      req.be    = MEM_BE_MAX'(req_be);
   end

   assign idx       = req_addr[IW-1:0];
   assign in_range  = ({1'b0, req_addr} < (P_ADDR_WIDTH + 1)'(P_DEPTH));
   // ready_en holds req_ready low until the first edge after reset release
   assign req_ready = ready_en && (outstanding < CW'(P_RSP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

`ifdef RISCV_MEM_WR_ACK_EN
   assign rsp_accept = accept;
`else
   assign rsp_accept = accept && !req_we;
`endif

   assign wr_merged = f_be_merge(MEM_DW_MAX'(mem[idx]), req.wdata, req.be);

   always_ff @(posedge clk) begin
      if (accept && req_we && in_range) mem[idx] <= wr_merged[P_DATA_WIDTH-1:0];
   end

   always_comb begin
      stage_in     = '0;
      stage_in.err = !in_range;
      if (!req_we && in_range) stage_in.rdata = MEM_DW_MAX'(mem[idx]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i < P_LATENCY; i++) pipe_d[i] <= '0;
      end else begin
         pipe_v[0] <= rsp_accept;
         pipe_d[0] <= stage_in;
         for (int unsigned i = 1; i < P_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   // outstanding spans pipe and FIFO, so capping it at P_RSP_DEPTH keeps pushes lossless
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_en    <= 1'b0;
         outstanding <= '0;
      end else begin
         ready_en <= 1'b1;
         case ({rsp_accept, pop})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   riscv_mem_rsp_fifo #(
      .P_DEPTH (P_RSP_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (pipe_v[P_LATENCY-1]),
      .push_data  (pipe_d[P_LATENCY-1]),
      .pop        (pop),
      .head       (head),
      .head_valid (rsp_valid),
      .count      (fifo_count)
   );

   assign rsp_rdata = head.rdata[P_DATA_WIDTH-1:0];
   assign rsp_err   = head.err;

   assign unused_bits = ^{req, wr_merged, head, fifo_count};

endmodule
